// File: rtl/mux_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the mux round-robin arbiter.
// master = arbiter side (drives grant, select, status); slave = requester side.
interface mux_rr_arbiter_if;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] sel;
   logic       busy;
   logic       timeout;

   modport master (
      input  req,
      output gnt,
      output sel,
      output busy,
      output timeout
   );

   modport slave (
      output req,
      input  gnt,
      input  sel,
      input  busy,
      input  timeout
   );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin owner arbiter for an 8:1 mux: registered one-hot grant + select, one-cycle gap between owners.
// Optional hold timeout compiled in with `define MUX_ARB_TIMEOUT_EN (uses MAX_HOLD / CNT_W).
module mux_rr_arbiter #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic            clk,
   input  logic            rst,
   mux_rr_arbiter_if.master bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t     state_reg, state_next;
   logic [7:0] gnt_reg,   gnt_next;
   logic [2:0] sel_reg,   sel_next;
   logic [2:0] last_reg,  last_next;
   logic       busy_reg,  busy_next;

   // Requests rotated so that bit 0 is the index right after the last owner.
   logic [7:0] req_rot;
   logic       win_found;
   logic [2:0] win_idx;

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_rot
         assign req_rot[gi] = bus.req[3'(last_reg + 3'(gi + 1))];
      end
   endgenerate

   // Lowest rotated position wins; the previous owner sits at position 7 and so ranks last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = last_reg;
      for (int i = 7; i >= 0; i--) begin
         if (req_rot[i]) begin
            win_found = 1'b1;
            win_idx   = last_reg + 3'(i + 1);
         end
      end
   end

   // MAX_HOLD / CNT_W only shape the timeout path; the legality guard references them in every build.
   generate
      if (MAX_HOLD < 1 || MAX_HOLD > 255 || CNT_W < 1 || CNT_W > 31 ||
          (64'd1 << CNT_W) <= 64'(MAX_HOLD)) begin : g_illegal_params
      end
   endgenerate

`ifdef MUX_ARB_TIMEOUT_EN
   logic [CNT_W-1:0] hold_cnt_reg, hold_cnt_next;
   logic             timeout_reg,  timeout_next;
`endif

   always_comb begin
      state_next = state_reg;
      gnt_next   = gnt_reg;
      sel_next   = sel_reg;
      last_next  = last_reg;
      busy_next  = busy_reg;
`ifdef MUX_ARB_TIMEOUT_EN
      hold_cnt_next = hold_cnt_reg;
      timeout_next  = 1'b0;
`endif

      case (state_reg)
         IDLE, GAP: begin
            if (win_found) begin
               state_next = GRANT;
               gnt_next   = 8'd1 << win_idx;
               sel_next   = win_idx;
               last_next  = win_idx;
               busy_next  = 1'b1;
`ifdef MUX_ARB_TIMEOUT_EN
               hold_cnt_next = '0;
`endif
            end else begin
               state_next = IDLE;
               gnt_next   = '0;
               busy_next  = 1'b0;
            end
         end

         GRANT: begin
            // Release is checked first so it takes precedence over a coincident timeout.
            if (!bus.req[sel_reg]) begin
               state_next = GAP;
               gnt_next   = '0;
            end
`ifdef MUX_ARB_TIMEOUT_EN
            else if (hold_cnt_reg == CNT_W'(MAX_HOLD - 1)) begin
               state_next   = GAP;
               gnt_next     = '0;
               timeout_next = 1'b1;
            end else if (hold_cnt_reg != '1) begin
               hold_cnt_next = hold_cnt_reg + CNT_W'(1);
            end
`endif
         end

         default: begin
            state_next = IDLE;
            gnt_next   = '0;
            busy_next  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= IDLE;
         gnt_reg   <= '0;
         sel_reg   <= '0;
         last_reg  <= 3'd7;
         busy_reg  <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
         hold_cnt_reg <= '0;
         timeout_reg  <= 1'b0;
`endif
      end else begin
         state_reg <= state_next;
         gnt_reg   <= gnt_next;
         sel_reg   <= sel_next;
         last_reg  <= last_next;
         busy_reg  <= busy_next;
`ifdef MUX_ARB_TIMEOUT_EN
         hold_cnt_reg <= hold_cnt_next;
         timeout_reg  <= timeout_next;
`endif
      end
   end

   assign bus.gnt  = gnt_reg;
   assign bus.sel  = sel_reg;
   assign bus.busy = busy_reg;
`ifdef MUX_ARB_TIMEOUT_EN
   assign bus.timeout = timeout_reg;
`else
   assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus a randomized run against a
// behavioural model, all expectations routed through a scoreboard queue.
module tb_mux_rr_arbiter;

   localparam int MAX_HOLD = 4;

   typedef struct packed {
      logic [7:0] gnt;
      logic [2:0] sel;
      logic       busy;
      logic       to;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   mux_rr_arbiter_if bus ();

   mux_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic exp_t mk(logic [7:0] g, int s, logic b, logic t);
      exp_t e;
      e.gnt  = g;
      e.sel  = 3'(s);
      e.busy = b;
      e.to   = t;
      return e;
   endfunction

   task automatic do_reset();
      rst     = 1'b1;
      bus.req = 8'h00;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      bus.req = 8'hFF;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (bus.gnt !== 8'h00) $display("FAIL reset_gnt: got %b expected 00000000", bus.gnt);
      else n_pass++;
      n_checks++;
      if (bus.sel !== 3'd0) $display("FAIL reset_sel: got %0d expected 0", bus.sel);
      else n_pass++;
      n_checks++;
      if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy);
      else n_pass++;
      n_checks++;
      if (bus.timeout !== 1'b0) $display("FAIL reset_timeout: got %b expected 0", bus.timeout);
      else n_pass++;
      bus.req = 8'h00;
      rst     = 1'b0;
   endtask

   task automatic test_single_release();
      logic [7:0] rq[$];
      exp_t ex[$];
      exp_t e, got;
      do_reset();
      rq.push_back(8'h04); ex.push_back(mk(8'h04, 2, 1, 0));
      rq.push_back(8'h04); ex.push_back(mk(8'h04, 2, 1, 0));
      rq.push_back(8'h00); ex.push_back(mk(8'h00, 2, 1, 0));
      rq.push_back(8'h00); ex.push_back(mk(8'h00, 2, 0, 0));
      rq.push_back(8'h00); ex.push_back(mk(8'h00, 2, 0, 0));
      foreach (rq[i]) begin
         bus.req = rq[i];
         sb.push_back(ex[i]);
         @(posedge clk);
         #1;
         e   = sb.pop_front();
         got = mk(bus.gnt, int'(bus.sel), bus.busy, bus.timeout);
         n_checks++;
         if (got !== e)
            $display("FAIL single_release cyc%0d: got gnt=%b sel=%0d busy=%b to=%b, expected gnt=%b sel=%0d busy=%b to=%b",
                     i, got.gnt, got.sel, got.busy, got.to, e.gnt, e.sel, e.busy, e.to);
         else n_pass++;
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] rq[$];
      exp_t ex[$];
      exp_t e, got;
      int   owner;
      do_reset();
      for (int r = 0; r < 4; r++) begin
         owner = (r % 2 == 0) ? 0 : 7;
         repeat (3) begin
            rq.push_back(8'h81);
            ex.push_back(mk(8'(1 << owner), owner, 1, 0));
         end
         rq.push_back((r == 3) ? 8'h00 : (8'h81 ^ 8'(1 << owner)));
         ex.push_back(mk(8'h00, owner, 1, 0));
      end
      rq.push_back(8'h00); ex.push_back(mk(8'h00, 7, 0, 0));
      foreach (rq[i]) begin
         bus.req = rq[i];
         sb.push_back(ex[i]);
         @(posedge clk);
         #1;
         e   = sb.pop_front();
         got = mk(bus.gnt, int'(bus.sel), bus.busy, bus.timeout);
         n_checks++;
         if (got !== e)
            $display("FAIL round_robin cyc%0d: got gnt=%b sel=%0d busy=%b to=%b, expected gnt=%b sel=%0d busy=%b to=%b",
                     i, got.gnt, got.sel, got.busy, got.to, e.gnt, e.sel, e.busy, e.to);
         else n_pass++;
      end
   endtask

   task automatic test_wrap();
      logic [7:0] rq[$];
      exp_t ex[$];
      exp_t e, got;
      do_reset();
      rq.push_back(8'h20); ex.push_back(mk(8'h20, 5, 1, 0));
      rq.push_back(8'h00); ex.push_back(mk(8'h00, 5, 1, 0));
      rq.push_back(8'h00); ex.push_back(mk(8'h00, 5, 0, 0));
      rq.push_back(8'h23); ex.push_back(mk(8'h01, 0, 1, 0));
      rq.push_back(8'h22); ex.push_back(mk(8'h00, 0, 1, 0));
      rq.push_back(8'h23); ex.push_back(mk(8'h02, 1, 1, 0));
      rq.push_back(8'h21); ex.push_back(mk(8'h00, 1, 1, 0));
      rq.push_back(8'h23); ex.push_back(mk(8'h20, 5, 1, 0));
      rq.push_back(8'h03); ex.push_back(mk(8'h00, 5, 1, 0));
      rq.push_back(8'h00); ex.push_back(mk(8'h00, 5, 0, 0));
      foreach (rq[i]) begin
         bus.req = rq[i];
         sb.push_back(ex[i]);
         @(posedge clk);
         #1;
         e   = sb.pop_front();
         got = mk(bus.gnt, int'(bus.sel), bus.busy, bus.timeout);
         n_checks++;
         if (got !== e)
            $display("FAIL wrap cyc%0d: got gnt=%b sel=%0d busy=%b to=%b, expected gnt=%b sel=%0d busy=%b to=%b",
                     i, got.gnt, got.sel, got.busy, got.to, e.gnt, e.sel, e.busy, e.to);
         else n_pass++;
      end
   endtask

   task automatic test_timeout();
      logic [7:0] rq[$];
      exp_t ex[$];
      exp_t e, got;
      do_reset();
`ifdef MUX_ARB_TIMEOUT_EN
      // Grant lasts MAX_HOLD cycles, then a gap with the pulse, then regrant; last round releases on the limit edge.
      for (int k = 0; k < 14; k++) begin
         rq.push_back(8'h08);
         if (k % (MAX_HOLD + 1) < MAX_HOLD) ex.push_back(mk(8'h08, 3, 1, 0));
         else                               ex.push_back(mk(8'h00, 3, 1, 1));
      end
      rq.push_back(8'h00); ex.push_back(mk(8'h00, 3, 1, 0));
      rq.push_back(8'h00); ex.push_back(mk(8'h00, 3, 0, 0));
`else
      for (int k = 0; k < 20; k++) begin
         rq.push_back(8'h08);
         ex.push_back(mk(8'h08, 3, 1, 0));
      end
      rq.push_back(8'h00); ex.push_back(mk(8'h00, 3, 1, 0));
      rq.push_back(8'h00); ex.push_back(mk(8'h00, 3, 0, 0));
`endif
      foreach (rq[i]) begin
         bus.req = rq[i];
         sb.push_back(ex[i]);
         @(posedge clk);
         #1;
         e   = sb.pop_front();
         got = mk(bus.gnt, int'(bus.sel), bus.busy, bus.timeout);
         n_checks++;
         if (got !== e)
            $display("FAIL timeout cyc%0d: got gnt=%b sel=%0d busy=%b to=%b, expected gnt=%b sel=%0d busy=%b to=%b",
                     i, got.gnt, got.sel, got.busy, got.to, e.gnt, e.sel, e.busy, e.to);
         else n_pass++;
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] rq[$];
      exp_t ex[$];
      exp_t e, got;
      do_reset();
      bus.req = 8'h10;
      @(posedge clk);
      #1;
      n_checks++;
      if (bus.gnt !== 8'h10) $display("FAIL async_pre_gnt: got %b expected 00010000", bus.gnt);
      else n_pass++;
      // Assert reset between edges and look before the next rising edge.
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (bus.gnt !== 8'h00) $display("FAIL async_gnt: got %b expected 00000000", bus.gnt);
      else n_pass++;
      n_checks++;
      if (bus.sel !== 3'd0) $display("FAIL async_sel: got %0d expected 0", bus.sel);
      else n_pass++;
      n_checks++;
      if (bus.busy !== 1'b0) $display("FAIL async_busy: got %b expected 0", bus.busy);
      else n_pass++;
      @(posedge clk);
      #1;
      rst = 1'b0;
      rq.push_back(8'hFF); ex.push_back(mk(8'h01, 0, 1, 0));
      rq.push_back(8'hFE); ex.push_back(mk(8'h00, 0, 1, 0));
      rq.push_back(8'hFE); ex.push_back(mk(8'h02, 1, 1, 0));
      rq.push_back(8'hFC); ex.push_back(mk(8'h00, 1, 1, 0));
      rq.push_back(8'h00); ex.push_back(mk(8'h00, 1, 0, 0));
      foreach (rq[i]) begin
         bus.req = rq[i];
         sb.push_back(ex[i]);
         @(posedge clk);
         #1;
         e   = sb.pop_front();
         got = mk(bus.gnt, int'(bus.sel), bus.busy, bus.timeout);
         n_checks++;
         if (got !== e)
            $display("FAIL async_after cyc%0d: got gnt=%b sel=%0d busy=%b to=%b, expected gnt=%b sel=%0d busy=%b to=%b",
                     i, got.gnt, got.sel, got.busy, got.to, e.gnt, e.sel, e.busy, e.to);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      int         ms, mlast, msel, mcnt, w;
      logic [7:0] mgnt, r;
      logic       mbusy, mto;
      exp_t       e, got;
      do_reset();
      ms = 0; mlast = 7; msel = 0; mcnt = 0; mgnt = 8'h00; mbusy = 1'b0;
      for (int c = 0; c < 150; c++) begin
         r = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 3) == 0) r = 8'h00;
         if (ms == 1 && $urandom_range(0, 4) != 0) r[msel] = 1'b1;
         mto = 1'b0;
         if (ms == 1) begin
            if (!r[msel]) begin
               ms = 2; mgnt = 8'h00;
            end
`ifdef MUX_ARB_TIMEOUT_EN
            else if (mcnt == MAX_HOLD - 1) begin
               ms = 2; mgnt = 8'h00; mto = 1'b1;
            end else begin
               mcnt++;
            end
`endif
         end else if (r != 8'h00) begin
            w = -1;
            for (int k = 1; k <= 8; k++) begin
               if (w < 0 && r[(mlast + k) % 8]) w = (mlast + k) % 8;
            end
            ms = 1; mgnt = 8'(1 << w); msel = w; mlast = w; mbusy = 1'b1; mcnt = 0;
         end else begin
            ms = 0; mbusy = 1'b0;
         end
         bus.req = r;
         sb.push_back(mk(mgnt, msel, mbusy, mto));
         @(posedge clk);
         #1;
         e   = sb.pop_front();
         got = mk(bus.gnt, int'(bus.sel), bus.busy, bus.timeout);
         n_checks++;
         if (got !== e)
            $display("FAIL random cyc%0d req=%b: got gnt=%b sel=%0d busy=%b to=%b, expected gnt=%b sel=%0d busy=%b to=%b",
                     c, r, got.gnt, got.sel, got.busy, got.to, e.gnt, e.sel, e.busy, e.to);
         else n_pass++;
         n_checks++;
         if ((bus.gnt & (bus.gnt - 8'd1)) !== 8'h00)
            $display("FAIL onehot cyc%0d: got gnt=%b expected zero or one-hot", c, bus.gnt);
         else n_pass++;
         n_checks++;
         if (bus.gnt !== 8'h00 && bus.gnt[bus.sel] !== 1'b1)
            $display("FAIL gnt_sel cyc%0d: got gnt=%b sel=%0d expected gnt[sel]=1", c, bus.gnt, bus.sel);
         else n_pass++;
      end
      bus.req = 8'h00;
   endtask

   initial begin
      bus.req = 8'h00;
      test_reset();
      test_single_release();
      test_round_robin();
      test_wrap();
      test_timeout();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, got time %0t expected finish earlier", $time);
      $fatal(1);
   end

endmodule
